// File: rtl/button_pkg.sv
// button_pkg: shared debounce FSM state encoding, default timing constants and counter-width helper
package button_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;
   localparam int CNT_MAX_DEF = 120000;
   localparam int REPEAT_CYCLES_DEF = 6000000;
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button bit, 2-flop synchronizer plus debounce FSM; BUTTON_REPEAT_EN adds auto-repeat in HELD
module debounce_channel
   import button_pkg::*;
#(
   parameter int CNT_MAX = CNT_MAX_DEF
`ifdef BUTTON_REPEAT_EN
   , parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic but_n,
   output logic pressed,
   output logic press,
   output logic rel
);
   localparam int CW = cnt_w(CNT_MAX);
   state_e state_q, state_d;
   logic [1:0] sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic pressed_q, pressed_d, press_q, press_d, rel_q, rel_d;
   logic s, last, rep_fire;
   assign s = ~sync_q[1];
   assign pressed = pressed_q;
   assign press = press_q;
   assign rel = rel_q;
   always_comb begin
      sync_d = {sync_q[0], but_n};
      state_d = state_q;
      cnt_d = '0;
      pressed_d = pressed_q;
      press_d = rep_fire;
      rel_d = 1'b0;
      last = cnt_q == CW'(CNT_MAX - 1);
      case (state_q)
         IDLE:
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d = CW'(1);
            end
         PRESS_WAIT:
            if (!s) state_d = IDLE;
            else if (last) begin
               state_d = HELD;
               pressed_d = 1'b1;
               press_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         HELD:
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d = CW'(1);
            end
         default:
            if (s) state_d = HELD;
            else if (last) begin
               state_d = IDLE;
               pressed_d = 1'b0;
               rel_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
      endcase
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         sync_q <= 2'b11;
         state_q <= IDLE;
         cnt_q <= '0;
         pressed_q <= 1'b0;
         press_q <= 1'b0;
         rel_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         pressed_q <= pressed_d;
         press_q <= press_d;
         rel_q <= rel_d;
      end
`ifdef BUTTON_REPEAT_EN
   localparam int RW = cnt_w(REPEAT_CYCLES);
   logic [RW-1:0] rep_q, rep_d;
   // Runs only while HELD stays held; any exit (or re-entry) restarts from zero.
   always_comb begin
      rep_fire = state_q == HELD && s && rep_q == RW'(REPEAT_CYCLES - 1);
      rep_d = (state_q == HELD && s && !rep_fire) ? rep_q + 1'b1 : '0;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) rep_q <= '0;
      else rep_q <= rep_d;
`else
   assign rep_fire = 1'b0;
`endif
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: WIDTH independent active-low button debouncers; define BUTTON_REPEAT_EN for PRESS auto-repeat
module button_debouncer
   import button_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int CNT_MAX = CNT_MAX_DEF
`ifdef BUTTON_REPEAT_EN
   , parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic [WIDTH-1:0] BUT,
   output logic [WIDTH-1:0] PRESSED,
   output logic [WIDTH-1:0] PRESS,
   output logic [WIDTH-1:0] RELEASE
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .CNT_MAX(CNT_MAX)
`ifdef BUTTON_REPEAT_EN
         , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
      ) u_ch (
         .CLK(CLK),
         .RST_N(RST_N),
         .but_n(BUT[i]),
         .pressed(PRESSED[i]),
         .press(PRESS[i]),
         .rel(RELEASE[i])
      );
   end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of button_debouncer at CNT_MAX=4 (REPEAT_CYCLES=8 under BUTTON_REPEAT_EN)
module tb_button_debouncer;
   logic CLK = 1'b0;
   logic RST_N;
   logic [1:0] BUT, PRESSED, PRESS, RELEASE;
   int vectors = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   button_debouncer #(
      .WIDTH(2),
      .CNT_MAX(4)
`ifdef BUTTON_REPEAT_EN
      , .REPEAT_CYCLES(8)
`endif
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .BUT(BUT),
      .PRESSED(PRESSED),
      .PRESS(PRESS),
      .RELEASE(RELEASE)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      BUT = 2'b11;
      tick(3);
      vectors++;
      if ({PRESSED, PRESS, RELEASE} !== 6'b0) begin
         errors++;
         $display("FAIL reset_hold: PRESSED=%b PRESS=%b RELEASE=%b, required all 00", PRESSED, PRESS, RELEASE);
      end
      RST_N = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick(1);
         vectors++;
         if ({PRESSED, PRESS, RELEASE} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required all 00", e, PRESSED, PRESS, RELEASE);
         end
      end
   endtask

   task automatic test_press_release;
      BUT = 2'b10;
      for (int e = 0; e <= 8; e++) begin
         tick(1);
         vectors++;
         if (PRESSED !== (e >= 5 ? 2'b01 : 2'b00) || PRESS !== (e == 5 ? 2'b01 : 2'b00) || RELEASE !== 2'b00) begin
            errors++;
            $display("FAIL press0 e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required %b %b 00", e, PRESSED, PRESS, RELEASE,
                     (e >= 5 ? 2'b01 : 2'b00), (e == 5 ? 2'b01 : 2'b00));
         end
      end
      BUT = 2'b11;
      for (int e = 0; e <= 8; e++) begin
         tick(1);
         vectors++;
         if (PRESSED !== (e >= 5 ? 2'b00 : 2'b01) || RELEASE !== (e == 5 ? 2'b01 : 2'b00) || PRESS !== 2'b00) begin
            errors++;
            $display("FAIL release0 e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required %b 00 %b", e, PRESSED, PRESS, RELEASE,
                     (e >= 5 ? 2'b00 : 2'b01), (e == 5 ? 2'b01 : 2'b00));
         end
      end
   endtask

   task automatic test_bounce;
      int presses = 0;
      int releases = 0;
      for (int e = 0; e < 12; e++) begin
         BUT = (e < 3 || e == 4 || e == 5) ? 2'b01 : 2'b11;
         tick(1);
         vectors++;
         if (PRESSED !== 2'b00 || PRESS !== 2'b00 || RELEASE !== 2'b00) begin
            errors++;
            $display("FAIL bounce1 e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required all 00", e, PRESSED, PRESS, RELEASE);
         end
      end
      BUT = 2'b01;
      for (int e = 0; e < 10; e++) begin
         tick(1);
         presses += int'(PRESS[1]);
      end
      vectors++;
      if (presses !== 1 || PRESSED !== 2'b10) begin
         errors++;
         $display("FAIL hold1: presses=%0d PRESSED=%b, required 1 and 10", presses, PRESSED);
      end
      BUT = 2'b11;
      for (int e = 0; e < 10; e++) begin
         tick(1);
         presses += int'(PRESS[1]);
         releases += int'(RELEASE[1]);
      end
      vectors++;
      if (presses !== 1 || releases !== 1 || PRESSED !== 2'b00) begin
         errors++;
         $display("FAIL unhold1: presses=%0d releases=%0d PRESSED=%b, required 1 1 00", presses, releases, PRESSED);
      end
   endtask

   task automatic test_simultaneous;
      BUT = 2'b00;
      for (int e = 0; e <= 6; e++) begin
         tick(1);
         vectors++;
         if (PRESSED !== (e >= 5 ? 2'b11 : 2'b00) || PRESS !== (e == 5 ? 2'b11 : 2'b00) || RELEASE !== 2'b00) begin
            errors++;
            $display("FAIL both_press e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required %b %b 00", e, PRESSED, PRESS, RELEASE,
                     (e >= 5 ? 2'b11 : 2'b00), (e == 5 ? 2'b11 : 2'b00));
         end
      end
      BUT = 2'b11;
      for (int e = 0; e <= 6; e++) begin
         tick(1);
         vectors++;
         if (PRESSED !== (e >= 5 ? 2'b00 : 2'b11) || RELEASE !== (e == 5 ? 2'b11 : 2'b00) || PRESS !== 2'b00) begin
            errors++;
            $display("FAIL both_release e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required %b 00 %b", e, PRESSED, PRESS, RELEASE,
                     (e >= 5 ? 2'b00 : 2'b11), (e == 5 ? 2'b11 : 2'b00));
         end
      end
   endtask

   task automatic test_reset_held;
      RST_N = 1'b0;
      BUT = 2'b10;
      tick(2);
      RST_N = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         tick(1);
         vectors++;
         if (PRESSED !== (e >= 5 ? 2'b01 : 2'b00) || PRESS !== (e == 5 ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL held_through_reset e=%0d: PRESSED=%b PRESS=%b, required %b %b", e, PRESSED, PRESS,
                     (e >= 5 ? 2'b01 : 2'b00), (e == 5 ? 2'b01 : 2'b00));
         end
      end
      tick(2);
      RST_N = 1'b0;
      #1;
      vectors++;
      if ({PRESSED, PRESS, RELEASE} !== 6'b0) begin
         errors++;
         $display("FAIL reset_while_held: PRESSED=%b PRESS=%b RELEASE=%b, required all 00", PRESSED, PRESS, RELEASE);
      end
      BUT = 2'b11;
      tick(3);
      RST_N = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick(1);
         vectors++;
         if ({PRESSED, PRESS, RELEASE} !== 6'b0) begin
            errors++;
            $display("FAIL after_reset_held e=%0d: PRESSED=%b PRESS=%b RELEASE=%b, required all 00", e, PRESSED, PRESS, RELEASE);
         end
      end
   endtask

   task automatic test_repeat;
      logic exp_press;
      BUT = 2'b10;
      for (int e = 0; e <= 45; e++) begin
         tick(1);
`ifdef BUTTON_REPEAT_EN
         exp_press = e >= 5 && (e - 5) % 8 == 0;
`else
         exp_press = e == 5;
`endif
         vectors++;
         if (PRESS !== {1'b0, exp_press} || PRESSED !== (e >= 5 ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL repeat e=%0d: PRESS=%b PRESSED=%b, required %b %b", e, PRESS, PRESSED, {1'b0, exp_press},
                     (e >= 5 ? 2'b01 : 2'b00));
         end
      end
      BUT = 2'b11;
      tick(10);
      vectors++;
      if (PRESSED !== 2'b00) begin
         errors++;
         $display("FAIL repeat_release: PRESSED=%b, required 00", PRESSED);
      end
   endtask

   initial begin
      test_reset;
      test_press_release;
      test_bounce;
      test_simultaneous;
      test_reset_held;
      test_repeat;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
